alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//   Shares one combinational ALU (a, b, aluop -> result, zero) between two requesters.
//   Round-robin arbitration with a valid/ready request and response handshake per requester.
//   Operands are held stable on the ALU for EXEC_CYCLES cycles, then result and zero are registered.
//   Sits between the ALU and its clients, e.g. the datapath issue stage and a debug/self-test port.
// PARAMETERS
//   WIDTH        32  operand/result width
//   OPW          4   aluop width
//   EXEC_CYCLES  1   cycles operands are held on the ALU before capture (>=1)
//   CNTW         16  width of ops_done counter
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   req0_valid   in   1      requester 0 has an operation
//   req0_ready   out  1      requester 0 operation accepted this cycle
//   req0_aluop   in   OPW    requester 0 opcode
//   req0_a       in   WIDTH  requester 0 operand a
//   req0_b       in   WIDTH  requester 0 operand b
//   rsp0_valid   out  1      result for requester 0 available
//   rsp0_ready   in   1      requester 0 consumes result
//   rsp0_result  out  WIDTH  result for requester 0
//   rsp0_zero    out  1      zero flag for requester 0
//   req1_*/rsp1_*             identical set for requester 1
//   alu_a        out  WIDTH  to ALU a
//   alu_b        out  WIDTH  to ALU b
//   alu_op       out  OPW    to ALU aluop
//   alu_result   in   WIDTH  from ALU result
//   alu_zero     in   1      from ALU zero
//   busy         out  1      high whenever state != IDLE
//   ops_done     out  CNTW   count of completed response handshakes
// BEHAVIOUR
//   Reset: state=IDLE, prio=0, all reqN_ready=0, rspN_valid=0, rspN_result=0, rspN_zero=0,
//     alu_a/alu_b/alu_op=0, busy=0, ops_done=0. Reset mid-operation discards the op; no response.
//   FSM states: IDLE, EXEC, RESP.
//   IDLE: grant is combinational. Both valid -> requester prio wins. One valid -> that one wins.
//     reqN_ready = (state==IDLE) & grant==N; at most one ready high.
//     On valid&ready: latch op/a/b into internal regs, owner=N, cnt=EXEC_CYCLES-1, go to EXEC.
//   EXEC: alu_a/alu_b/alu_op driven from the latched regs (registered; stable for the whole op).
//     cnt!=0: decrement. cnt==0: capture alu_result/alu_zero into rsp<owner>_result/_zero,
//     set rsp<owner>_valid=1, go to RESP.
//     Zero flag is taken from the ALU, not recomputed.
//   RESP: rsp<owner>_valid held with stable data until rsp<owner>_ready.
//     On handshake: rsp valid=0, prio=~owner, ops_done+=1 (wraps at 2^CNTW), go to IDLE.
//   rspN_result/_zero keep their last value after valid drops. reqN_ready=0 outside IDLE.
//   Latency: accept at edge T -> rsp valid after edge T+EXEC_CYCLES.
//     Minimum issue spacing is EXEC_CYCLES+2 cycles (response ready tied high).
//   reqN_valid must be held until ready; a valid dropped before ready is not executed.
//   alu_* keep the last op's values in IDLE/RESP (no glitching to 0).
//   rspN_ready while rspN_valid=0 is ignored. No back-to-back bypass from RESP to EXEC.
// TESTING
//   ALU stub: op 4'b0010 = add, 4'b0110 = sub, zero = (result==0).
//   1) Req0 only, op=0010, a=5, b=7, rsp0_ready=1 -> rsp0_valid one cycle after EXEC capture,
//      result=0x0000000C, zero=0, ops_done=1, rsp1_valid never high.
//   2) Both valid at once after reset, req0 op=0110 a=b=0x1234, req1 op=0010 a=1 b=1
//      -> req0 granted first: result 0, zero=1; then req1: result 2, zero=0. Order 0,1.
//   3) Both held valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; ops_done=6.
//   4) rsp1_ready held low 10 cycles -> rsp1_valid/result stable; req0_ready stays 0;
//      busy=1 throughout. Release -> IDLE next cycle.
//   5) EXEC_CYCLES=3: req0 a=0xFFFFFFFF b=1 op=0010 -> alu_* stable 3 cycles;
//      result=0, zero=1; req0 changing a during EXEC has no effect.
//   6) rst asserted in EXEC -> all outputs at reset values next cycle, no rsp_valid, ops_done=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are held on the ALU for EXEC_CYCLES cycles, then result/zero are registered per requester.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational, winner sees reqN_ready
// EXEC  | latched operands on alu_*; counting down until capture
// RESP  | rsp<owner>_valid held until the owner takes it
module alu_share_arb #(
  parameter int WIDTH       = 32,
  parameter int OPW         = 4,
  parameter int EXEC_CYCLES = 1,
  parameter int CNTW        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_aluop,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_aluop,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic [CNTW-1:0]  ops_done
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic          prio;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          grant_vld;
  logic          grant;
  logic          accept;
  logic          capture;
  logic          rsp_hs;

  // Both valid -> prio wins; otherwise the lone valid requester wins.
  assign grant_vld = req0_valid | req1_valid;
  assign grant     = (req0_valid & req1_valid) ? prio : req1_valid;
  assign accept    = (state == IDLE) & grant_vld;
  assign capture   = (state == EXEC) & (cnt == '0);
  assign rsp_hs    = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:    if (capture) state_nxt = RESP;
      RESP:    if (rsp_hs)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept & ~grant;
    req1_ready = accept & grant;
    busy       = (state != IDLE);
  end

  // alu_* double as the latched operand registers, so they hold through RESP and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
      ops_done    <= '0;
    end else begin
      if (accept) begin
        owner  <= grant;
        cnt    <= CW'(EXEC_CYCLES - 1);
        alu_a  <= grant ? req1_a : req0_a;
        alu_b  <= grant ? req1_b : req0_b;
        alu_op <= grant ? req1_aluop : req0_aluop;
      end
      if ((state == EXEC) && (cnt != '0)) cnt <= cnt - CW'(1);
      if (capture) begin
        if (owner) begin
          rsp1_valid  <= 1'b1;
          rsp1_result <= alu_result;
          rsp1_zero   <= alu_zero;
        end else begin
          rsp0_valid  <= 1'b1;
          rsp0_result <= alu_result;
          rsp0_zero   <= alu_zero;
        end
      end
      if (rsp_hs) begin
        if (owner) rsp1_valid <= 1'b0;
        else       rsp0_valid <= 1'b0;
        prio     <= ~owner;
        ops_done <= ops_done + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: two instances (EXEC_CYCLES 1 and 3), one active at a time,
// compared every cycle against a transaction-level model plus directed scenario checks.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        rst_i [2];
  logic        req_valid [2];
  logic [3:0]  req_op [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic        rsp_ready [2];

  logic        req_ready_o [2][2];
  logic        rsp_valid_o [2][2];
  logic [31:0] rsp_result_o [2][2];
  logic        rsp_zero_o [2][2];
  logic [31:0] alu_a_o [2];
  logic [31:0] alu_b_o [2];
  logic [3:0]  alu_op_o [2];
  logic [31:0] alu_res [2];
  logic        alu_z [2];
  logic        busy_o [2];
  logic [15:0] ops_o [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rst_i[0] = rst | sel;
  assign rst_i[1] = rst | ~sel;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return a & b;
    endcase
  endfunction

  assign alu_res[0] = alu_model(alu_op_o[0], alu_a_o[0], alu_b_o[0]);
  assign alu_res[1] = alu_model(alu_op_o[1], alu_a_o[1], alu_b_o[1]);
  assign alu_z[0]   = (alu_res[0] == 32'd0);
  assign alu_z[1]   = (alu_res[1] == 32'd0);

  alu_share_arb #(.EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst_i[0]),
    .req0_valid(req_valid[0]), .req0_ready(req_ready_o[0][0]), .req0_aluop(req_op[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]),
    .rsp0_valid(rsp_valid_o[0][0]), .rsp0_ready(rsp_ready[0]),
    .rsp0_result(rsp_result_o[0][0]), .rsp0_zero(rsp_zero_o[0][0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready_o[0][1]), .req1_aluop(req_op[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]),
    .rsp1_valid(rsp_valid_o[0][1]), .rsp1_ready(rsp_ready[1]),
    .rsp1_result(rsp_result_o[0][1]), .rsp1_zero(rsp_zero_o[0][1]),
    .alu_a(alu_a_o[0]), .alu_b(alu_b_o[0]), .alu_op(alu_op_o[0]),
    .alu_result(alu_res[0]), .alu_zero(alu_z[0]),
    .busy(busy_o[0]), .ops_done(ops_o[0])
  );

  alu_share_arb #(.EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst_i[1]),
    .req0_valid(req_valid[0]), .req0_ready(req_ready_o[1][0]), .req0_aluop(req_op[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]),
    .rsp0_valid(rsp_valid_o[1][0]), .rsp0_ready(rsp_ready[0]),
    .rsp0_result(rsp_result_o[1][0]), .rsp0_zero(rsp_zero_o[1][0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready_o[1][1]), .req1_aluop(req_op[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]),
    .rsp1_valid(rsp_valid_o[1][1]), .rsp1_ready(rsp_ready[1]),
    .rsp1_result(rsp_result_o[1][1]), .rsp1_zero(rsp_zero_o[1][1]),
    .alu_a(alu_a_o[1]), .alu_b(alu_b_o[1]), .alu_op(alu_op_o[1]),
    .alu_result(alu_res[1]), .alu_zero(alu_z[1]),
    .busy(busy_o[1]), .ops_done(ops_o[1])
  );

  // Reference model: age is cycles since acceptance (-1 when nothing is in flight).
  int          ex = 1;
  int          age = -1;
  int          accepted = -1;
  int          m_ops = 0;
  bit          m_prio = 0;
  bit          m_owner = 0;
  bit          m_rspv [2];
  logic [31:0] m_res [2];
  bit          m_zero [2];
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  bit          pend [2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (req_valid[0] && req_valid[1]) return int'(m_prio);
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  task automatic model_update();
    int g;
    g = m_grant();
    accepted = -1;
    if (rst) begin
      age = -1; m_prio = 0; m_owner = 0; m_ops = 0;
      m_rspv = '{0, 0}; m_res = '{32'd0, 32'd0}; m_zero = '{0, 0};
      m_a = '0; m_b = '0; m_op = '0;
    end else if (age < 0) begin
      if (g >= 0) begin
        accepted = g;
        m_owner  = g[0];
        m_a = req_a[g]; m_b = req_b[g]; m_op = req_op[g];
        age = 0;
      end
    end else if (age < ex) begin
      age++;
      if (age == ex) begin
        m_rspv[m_owner] = 1;
        m_res[m_owner]  = alu_model(m_op, m_a, m_b);
        m_zero[m_owner] = (m_res[m_owner] == 32'd0);
      end
    end else if (rsp_ready[m_owner]) begin
      m_rspv[m_owner] = 0;
      m_prio = !m_owner;
      m_ops++;
      age = -1;
    end
  endtask

  // Called at the falling edge with inputs already set for the coming rising edge.
  task automatic step();
    int g;
    #1;
    g = m_grant();
    check_val("req0_ready", req_ready_o[sel][0], (age < 0) && (g == 0));
    check_val("req1_ready", req_ready_o[sel][1], (age < 0) && (g == 1));
    for (int n = 0; n < 2; n++) begin
      check_val($sformatf("rsp%0d_valid", n), rsp_valid_o[sel][n], m_rspv[n]);
      check_val($sformatf("rsp%0d_result", n), rsp_result_o[sel][n], m_res[n]);
      check_val($sformatf("rsp%0d_zero", n), rsp_zero_o[sel][n], m_zero[n]);
    end
    check_val("alu_a", alu_a_o[sel], m_a);
    check_val("alu_b", alu_b_o[sel], m_b);
    check_val("alu_op", alu_op_o[sel], m_op);
    check_val("busy", busy_o[sel], age >= 0);
    check_val("ops_done", ops_o[sel], 16'(m_ops));
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '{0, 0};
    pend = '{0, 0};
    model_update();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[n] = 1'b1; req_op[n] = op; req_a[n] = a; req_b[n] = b;
  endtask

  task automatic rand_inputs();
    for (int n = 0; n < 2; n++) begin
      if (!pend[n] && $urandom_range(0, 2) == 0) begin
        pend[n] = 1;
        case ($urandom_range(0, 2))
          0: req_op[n] = 4'b0010;
          1: req_op[n] = 4'b0110;
          default: req_op[n] = 4'($urandom);
        endcase
        req_a[n] = $urandom;
        req_b[n] = ($urandom_range(0, 3) == 0) ? req_a[n] : 32'($urandom);
      end else if (pend[n] && $urandom_range(0, 19) == 0) begin
        pend[n] = 0;
      end
      if (!pend[n]) begin
        req_a[n] = $urandom;
        req_b[n] = $urandom;
      end
      req_valid[n] = pend[n];
      rsp_ready[n] = ($urandom_range(0, 9) < 7);
    end
    rst = ($urandom_range(0, 199) == 0);
  endtask

  task automatic rand_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rand_inputs();
      step();
      if (accepted >= 0) pend[accepted] = 0;
    end
    rst = 1'b0;
  endtask

  initial begin
    int n;
    req_valid = '{0, 0}; req_op = '{4'd0, 4'd0};
    req_a = '{32'd0, 32'd0}; req_b = '{32'd0, 32'd0};
    rsp_ready = '{1, 1};
    sel = 1'b0; ex = 1;
    do_reset();

    // single requester add
    set_req(0, 4'b0010, 32'd5, 32'd7);
    step();
    req_valid[0] = 1'b0;
    step();
    check_val("t1_valid", rsp_valid_o[0][0], 1'b1);
    check_val("t1_result", rsp_result_o[0][0], 32'h0000000C);
    check_val("t1_zero", rsp_zero_o[0][0], 1'b0);
    step();
    check_val("t1_ops", ops_o[0], 16'd1);

    // simultaneous requests after reset: requester 0 first
    do_reset();
    set_req(0, 4'b0110, 32'h1234, 32'h1234);
    set_req(1, 4'b0010, 32'd1, 32'd1);
    step();
    req_valid[0] = 1'b0;
    step();
    check_val("t2_res0", rsp_result_o[0][0], 32'd0);
    check_val("t2_zero0", rsp_zero_o[0][0], 1'b1);
    step();
    step();
    req_valid[1] = 1'b0;
    step();
    check_val("t2_res1", rsp_result_o[0][1], 32'd2);
    check_val("t2_zero1", rsp_zero_o[0][1], 1'b0);
    check_val("t2_valid0", rsp_valid_o[0][0], 1'b0);
    step();

    // continuous contention alternates grants
    do_reset();
    set_req(0, 4'b0010, $urandom, $urandom);
    set_req(1, 4'b0110, $urandom, $urandom);
    for (int c = 0; c < 18; c++) begin
      step();
      if (accepted >= 0) begin
        req_a[accepted] = $urandom;
        req_b[accepted] = $urandom;
      end
    end
    check_val("t3_ops", ops_o[0], 16'd6);
    req_valid = '{0, 0};

    // response backpressure on requester 1
    do_reset();
    set_req(1, 4'b0010, $urandom, $urandom);
    rsp_ready[1] = 1'b0;
    step();
    req_valid[1] = 1'b0;
    set_req(0, 4'b0110, 32'd9, 32'd4);
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      check_val("t4_busy", busy_o[0], 1'b1);
      check_val("t4_r0rdy", req_ready_o[0][0], 1'b0);
    end
    rsp_ready[1] = 1'b1;
    step();
    check_val("t4_idle", busy_o[0], 1'b0);
    req_valid[0] = 1'b0;
    step();

    // reset during execution
    do_reset();
    set_req(0, 4'b0010, 32'd3, 32'd4);
    step();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_valid", rsp_valid_o[0][0], 1'b0);
    check_val("t6_ops", ops_o[0], 16'd0);
    check_val("t6_alu_a", alu_a_o[0], 32'd0);
    step();
    step();
    check_val("t6_novalid", rsp_valid_o[0][0], 1'b0);

    rand_run(3000);

    // three-cycle execution instance
    sel = 1'b1; ex = 3;
    do_reset();
    set_req(0, 4'b0010, 32'hFFFFFFFF, 32'd1);
    step();
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid_o[1][0] && n < 10) begin
      check_val("t5_alu_a", alu_a_o[1], 32'hFFFFFFFF);
      req_a[0] = $urandom;
      step();
      n++;
    end
    check_val("t5_latency", n, 3);
    check_val("t5_result", rsp_result_o[1][0], 32'd0);
    check_val("t5_zero", rsp_zero_o[1][0], 1'b1);
    step();

    rand_run(3000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
